dcache_mem_ctrl: RTL and testbench

- Memory-side sequencer for the pipelined core's data cache; sits directly downstream of the data-cache control FSM.
- Services line-fill (LOAD) and dirty-victim write-back (WRITE_BACK) requests by bursting a full cache line word-by-word over a ready-handshaked main-memory port.
- Writes fill words into the cache data array; reads victim words from it.
- Pulses done so the cache FSM can release the pipeline stall.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_mem_ctrl_line_word_counter.sv | 31 +++
 rtl/dcache_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache memory sequencer, cache FSM and data array.
package dcache_pkg;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_IDX_W          = $clog2(DEF_WORDS_PER_LINE);
  localparam int DEF_OFF            = DEF_IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte-offset width of a line holding the given number of 32-bit words.
  function automatic int line_off(input int words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl_line_word_counter.sv
// Word index within the cache line being burst; clear wins over advance.
module line_word_counter
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int IDX_W = $clog2(WORDS_PER_LINE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] count,
  output logic             last
);

  logic [IDX_W-1:0] count_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (advance) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Bursts a dirty victim line out to memory and/or a missed line in from memory,
// one word per mem_ready, then pulses done back to the cache FSM.
module dcache_mem_ctrl
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  localparam int IDX_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_wb,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              busy,
  output logic              done,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int OFF    = line_off(WORDS_PER_LINE);
  localparam int BASE_W = ADDR_W - OFF;

  state_t            state_reg, state_next;
  logic [BASE_W-1:0] victim_base_reg, fill_base_reg;
  logic              fill_pend_reg;
  logic              accept;
  logic              cnt_clear, cnt_advance, cnt_last;
  logic [IDX_W-1:0]  cnt;

  line_word_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_counter (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (cnt_clear),
    .advance(cnt_advance),
    .count  (cnt),
    .last   (cnt_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg       <= IDLE;
      victim_base_reg <= '0;
      fill_base_reg   <= '0;
      fill_pend_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        victim_base_reg <= victim_addr[ADDR_W-1:OFF];
        fill_base_reg   <= fill_addr[ADDR_W-1:OFF];
        fill_pend_reg   <= req_fill;
      end
    end
  end

  // Outputs decode straight from state so an async reset drops them immediately.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    fill_we     = 1'b0;
    fill_data   = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (req_valid) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          if (req_wb)        state_next = WB;
          else if (req_fill) state_next = FILL;
          else               state_next = DONE;
        end
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = {victim_base_reg, cnt, 2'b00};
        mem_wdata = wb_data;
        if (mem_ready) begin
          cnt_advance = 1'b1;
          if (cnt_last) begin
            cnt_clear  = 1'b1;
            state_next = fill_pend_reg ? FILL : DONE;
          end
        end
      end
      FILL: begin
        mem_re   = 1'b1;
        mem_addr = {fill_base_reg, cnt, 2'b00};
        if (mem_ready) begin
          fill_we     = 1'b1;
          fill_data   = mem_rdata;
          cnt_advance = 1'b1;
          if (cnt_last) begin
            cnt_clear  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign fill_idx = cnt;
  assign wb_idx   = cnt;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Randomised self-checking bench: each request is expanded into the expected list
// of memory accesses and array writes, which the DUT must consume in order.
module tb_dcache_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
  logic [31:0] victim_addr = '0, fill_addr = '0;
  logic        busy, done, fill_we, mem_re, mem_we;
  logic [2:0]  fill_idx, wb_idx;
  logic [31:0] fill_data, wb_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;

  logic [31:0] line_arr [8];
  logic [31:0] rd_base = 32'hA0;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } acc_t;

  always #5 CLK = ~CLK;

  // Array and memory models: victim words from line_arr, read data tied to the word index.
  assign wb_data   = line_arr[wb_idx];
  assign mem_rdata = rd_base + {29'd0, mem_addr[4:2]};

  dcache_mem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_wb(req_wb), .req_fill(req_fill),
    .victim_addr(victim_addr), .fill_addr(fill_addr),
    .busy(busy), .done(done),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // extra_at >= 0: spurious request while fill word extra_at is pending;
  // extra_at == -2: spurious request during the done cycle. exp_lat < 0: latency unchecked.
  task automatic run_txn(input string name, input bit wb, input bit fl,
                         input logic [31:0] va, input logic [31:0] fa, input logic [31:0] base,
                         input int mode, input int extra_at, input int exp_lat);
    acc_t q[$];
    acc_t a;
    int   cyc, fills_done, done_cyc;
    bit   injected, exp_fw;
    rd_base = base;
    for (int i = 0; i < 8; i++) line_arr[i] = $urandom;
    if (wb) for (int i = 0; i < 8; i++) begin
      a.we = 1'b1; a.addr = (va & ~32'h1F) + 32'(i * 4); a.data = line_arr[i]; a.idx = i;
      q.push_back(a);
    end
    if (fl) for (int i = 0; i < 8; i++) begin
      a.we = 1'b0; a.addr = (fa & ~32'h1F) + 32'(i * 4); a.data = base + 32'(i); a.idx = i;
      q.push_back(a);
    end
    @(posedge CLK); #1;
    req_valid = 1'b1; req_wb = wb; req_fill = fl; victim_addr = va; fill_addr = fa;
    mem_ready = 1'($urandom);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_wb = 1'($urandom); req_fill = 1'($urandom);
    victim_addr = $urandom; fill_addr = $urandom;
    cyc = 1; fills_done = 0; done_cyc = 0; injected = 1'b0;
    while (done_cyc == 0 && cyc <= 400) begin
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (cyc % 3 == 0);
        default: mem_ready = 1'($urandom);
      endcase
      req_valid = 1'b0;
      if (!injected && ((extra_at >= 0 && q.size() > 0 && !q[0].we && fills_done == extra_at) ||
                        (extra_at == -2 && q.size() == 0))) begin
        req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b1; injected = 1'b1;
      end
      @(negedge CLK);
      checks++;
      if (mem_re && mem_we) $display("FAIL %s both_strobes cyc=%0d: re=%b we=%b required not both", name, cyc, mem_re, mem_we);
      else passed++;
      checks++;
      if (busy !== 1'b1) $display("FAIL %s busy cyc=%0d: got %b want 1", name, cyc, busy);
      else passed++;
      if (q.size() == 0) begin
        done_cyc = cyc;
        checks++;
        if (done !== 1'b1) $display("FAIL %s done cyc=%0d: got %b want 1", name, cyc, done);
        else passed++;
        checks++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || fill_we !== 1'b0)
          $display("FAIL %s strobes_in_done: re=%b we=%b fill_we=%b want 000", name, mem_re, mem_we, fill_we);
        else passed++;
        if (exp_lat >= 0) begin
          checks++;
          if (cyc != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
          else passed++;
        end
      end else begin
        a = q[0];
        if (done === 1'b1) done_cyc = cyc;
        checks++;
        if (done !== 1'b0) $display("FAIL %s early_done cyc=%0d: got %b want 0 (%0d left)", name, cyc, done, q.size());
        else passed++;
        checks++;
        if (mem_we !== a.we || mem_re !== !a.we)
          $display("FAIL %s strobe cyc=%0d: re=%b we=%b want re=%b we=%b", name, cyc, mem_re, mem_we, !a.we, a.we);
        else passed++;
        checks++;
        if (mem_addr !== a.addr) $display("FAIL %s mem_addr cyc=%0d: got %h want %h", name, cyc, mem_addr, a.addr);
        else passed++;
        if (a.we) begin
          checks++;
          if (mem_wdata !== a.data || wb_idx !== a.idx[2:0])
            $display("FAIL %s wb_word cyc=%0d: wdata=%h idx=%0d want %h idx=%0d", name, cyc, mem_wdata, wb_idx, a.data, a.idx);
          else passed++;
        end
        exp_fw = !a.we && mem_ready;
        checks++;
        if (fill_we !== exp_fw) $display("FAIL %s fill_we cyc=%0d: got %b want %b", name, cyc, fill_we, exp_fw);
        else passed++;
        if (exp_fw) begin
          checks++;
          if (fill_idx !== a.idx[2:0] || fill_data !== a.data)
            $display("FAIL %s fill_word cyc=%0d: idx=%0d data=%h want idx=%0d data=%h", name, cyc, fill_idx, fill_data, a.idx, a.data);
          else passed++;
        end
        if (mem_ready) begin
          void'(q.pop_front());
          if (!a.we) fills_done++;
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    checks++;
    if (done_cyc == 0) $display("FAIL %s timeout: no done within %0d cycles", name, cyc - 1);
    else passed++;
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'($urandom);
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL %s idle_after_done+%0d: busy=%b done=%b re=%b we=%b want 0000", name, k + 1, busy, done, mem_re, mem_we);
      else passed++;
      @(posedge CLK); #1;
    end
    $display("txn %-14s wb=%0d fill=%0d va=%h fa=%h mode=%0d done_cyc=%0d", name, wb, fl, va, fa, mode, done_cyc);
  endtask

  task automatic test_reset();
    RST = 1'b0; req_valid = 1'b1; req_wb = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fill_we !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL reset_strobes: busy=%b done=%b fill_we=%b re=%b we=%b want 0", busy, done, fill_we, mem_re, mem_we);
      else passed++;
      checks++;
      if (mem_addr !== 32'h0 || fill_idx !== 3'd0 || wb_idx !== 3'd0)
        $display("FAIL reset_addr_idx: mem_addr=%h fill_idx=%0d wb_idx=%0d want 0", mem_addr, fill_idx, wb_idx);
      else passed++;
      @(posedge CLK);
    end
    req_valid = 1'b0; req_wb = 1'b0; mem_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    $display("txn reset         outputs checked while RST low");
  endtask

  task automatic test_fill_only();
    run_txn("fill_only", 1'b0, 1'b1, $urandom, 32'h0000_1234, 32'hA0, 0, -1, 9);
  endtask

  task automatic test_dirty_miss();
    run_txn("dirty_miss", 1'b1, 1'b1, 32'h0000_4000, 32'h0000_8000, $urandom, 0, -1, 17);
  endtask

  task automatic test_ready_stall();
    run_txn("ready_stall", 1'b0, 1'b1, $urandom, 32'h0000_2468, $urandom, 1, -1, 25);
  endtask

  task automatic test_request_while_busy();
    run_txn("req_while_busy", 1'b0, 1'b1, $urandom, 32'h0000_3300, $urandom, 0, 3, 9);
  endtask

  task automatic test_null_request();
    run_txn("null_request", 1'b0, 1'b0, $urandom, $urandom, $urandom, 0, -2, 1);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) line_arr[i] = $urandom;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b1;
    victim_addr = 32'h0000_5000; fill_addr = 32'h0000_6000;
    @(posedge CLK); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0000_5014)
      $display("FAIL rst_mid_pre: we=%b addr=%h want we=1 addr=00005014", mem_we, mem_addr);
    else passed++;
    #1 RST = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 || wb_idx !== 3'd0)
      $display("FAIL rst_mid_drop: we=%b busy=%b addr=%h wb_idx=%0d want 0", mem_we, busy, mem_addr, wb_idx);
    else passed++;
    #1 RST = 1'b1;
    $display("txn rst_mid_burst  reset asserted during write-back word 5");
    run_txn("post_reset_fill", 1'b0, 1'b1, $urandom, 32'h0000_7010, $urandom, 0, -1, 9);
  endtask

  task automatic test_random();
    bit wb, fl;
    for (int t = 0; t < 20; t++) begin
      wb = 1'($urandom); fl = 1'($urandom);
      run_txn("random", wb, fl, $urandom, $urandom, $urandom, 2, ($urandom % 4 == 0) ? 2 : -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_only();
    test_dirty_miss();
    test_ready_stall();
    test_request_while_busy();
    test_null_request();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
